// File: rtl/i2c_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_pkg
//  Description : Shared definitions for the I2C transaction arbiter:
//                controller state encoding, I2C field widths and the default
//                transaction time budget.
//  Revision    : 1.0 - initial release
// ============================================================================
package i2c_pkg;

    localparam int ADDR_W          = 7;    // 7-bit I2C slave address
    localparam int DATA_W          = 16;   // 16-bit data word
    localparam int XFER_CYCLES_DEF = 256;  // default CLK cycles per transaction

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/i2c_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_rr_pick
//  Description : Combinational round-robin picker. Scans the request vector
//                starting one position after the previous winner, wrapping
//                modulo NUM_REQ, and reports the first set bit.
//  Ports       : req        - request vector
//                last_grant - index of the previous winner
//                winner_oh  - one-hot winner (all zero when nothing requests)
//                winner_idx - binary index of the winner
//                any_req    - at least one request is set
//  Revision    : 1.0 - initial release
// ============================================================================
module i2c_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [NUM_REQ-1:0] winner_oh,
    output logic [IDX_W-1:0]   winner_idx,
    output logic               any_req
);

    logic w_found;
    int   w_cand;

    always_comb begin
        winner_oh  = '0;
        winner_idx = '0;
        w_found    = 1'b0;
        w_cand     = 0;
        // Offsets 1..NUM_REQ visit every requester once, ending with the
        // previous winner itself, so a lone persistent requester still wins.
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_cand = int'(last_grant) + k;
            if (w_cand >= NUM_REQ) begin
                w_cand = w_cand - NUM_REQ;
            end
            if (!w_found && req[w_cand]) begin
                w_found            = 1'b1;
                winner_idx         = IDX_W'(w_cand);
                winner_oh[w_cand]  = 1'b1;
            end
        end
    end

    assign any_req = |req;

endmodule
`default_nettype wire

// File: rtl/i2c_txn_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_txn_arbiter
//  Description : Shares a single I2C master between NUM_REQ requesters.
//                Round-robin arbitration, operand latching onto the master,
//                fixed-budget transaction timing (the master has no done
//                flag), read-data return and a one-cycle DONE to the owner.
//  Ports       : CLK, RST (synchronous, active-low)
//                REQ/REQ_RNW/REQ_ADDR/REQ_WDATA - per-requester request,
//                    direction and packed operands
//                GNT/DONE/RDATA/BUSY - requester-side status
//                M_START_STB/M_RNW/M_ADDR/M_WDATA/M_RDATA - master side
//  Revision    : 1.0 - initial release
// ============================================================================
module i2c_txn_arbiter
    import i2c_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int XFER_CYCLES = XFER_CYCLES_DEF,
    parameter int CNT_W       = $clog2(XFER_CYCLES + 1)
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic [NUM_REQ-1:0]          REQ,
    input  logic [NUM_REQ-1:0]          REQ_RNW,
    input  logic [ADDR_W*NUM_REQ-1:0]   REQ_ADDR,
    input  logic [DATA_W*NUM_REQ-1:0]   REQ_WDATA,
    output logic [NUM_REQ-1:0]          GNT,
    output logic [NUM_REQ-1:0]          DONE,
    output logic [DATA_W-1:0]           RDATA,
    output logic                        BUSY,
    output logic                        M_START_STB,
    output logic                        M_RNW,
    output logic [ADDR_W-1:0]           M_ADDR,
    output logic [DATA_W-1:0]           M_WDATA,
    input  logic [DATA_W-1:0]           M_RDATA
);

    localparam int IDX_W = $clog2(NUM_REQ);

    localparam logic [CNT_W-1:0] c_timer_load = CNT_W'(XFER_CYCLES - 1);
    localparam logic [IDX_W-1:0] c_last_rst   = IDX_W'(NUM_REQ - 1);

    arb_state_t          r_state,  w_state_nxt;
    logic [CNT_W-1:0]    r_timer,  w_timer_nxt;
    logic [IDX_W-1:0]    r_last,   w_last_nxt;
    logic [NUM_REQ-1:0]  r_gnt,    w_gnt_nxt;
    logic [NUM_REQ-1:0]  r_done,   w_done_nxt;
    logic [DATA_W-1:0]   r_rdata,  w_rdata_nxt;
    logic                r_busy,   w_busy_nxt;
    logic                r_stb,    w_stb_nxt;
    logic                r_rnw,    w_rnw_nxt;
    logic [ADDR_W-1:0]   r_addr,   w_addr_nxt;
    logic [DATA_W-1:0]   r_wdata,  w_wdata_nxt;

    logic [NUM_REQ-1:0]  w_win_oh;
    logic [IDX_W-1:0]    w_win_idx;
    logic                w_any_req;

    i2c_rr_pick #(
        .NUM_REQ    (NUM_REQ),
        .IDX_W      (IDX_W)
    ) u_pick (
        .req        (REQ),
        .last_grant (r_last),
        .winner_oh  (w_win_oh),
        .winner_idx (w_win_idx),
        .any_req    (w_any_req)
    );

    // ------------------------------------------------------------------
    // Next-state and registered-output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_last_nxt  = r_last;
        w_gnt_nxt   = r_gnt;
        w_done_nxt  = '0;
        w_rdata_nxt = r_rdata;
        w_busy_nxt  = r_busy;
        w_stb_nxt   = 1'b0;       // strobe only ever lasts one cycle
        w_rnw_nxt   = r_rnw;
        w_addr_nxt  = r_addr;
        w_wdata_nxt = r_wdata;

        case (r_state)
            IDLE: begin
                if (w_any_req) begin
                    w_state_nxt = RUN;
                    w_gnt_nxt   = w_win_oh;
                    w_busy_nxt  = 1'b1;
                    w_stb_nxt   = 1'b1;
                    w_last_nxt  = w_win_idx;
                    w_timer_nxt = c_timer_load;
                    w_rnw_nxt   = REQ_RNW[w_win_idx];
                    w_addr_nxt  = REQ_ADDR[int'(w_win_idx)*ADDR_W +: ADDR_W];
                    w_wdata_nxt = REQ_WDATA[int'(w_win_idx)*DATA_W +: DATA_W];
                end
            end

            RUN: begin
                if (r_timer == '0) begin
                    w_state_nxt = FIN;
                    w_done_nxt  = r_gnt;
                    // Read data is taken at the edge that enters FIN so it
                    // is presented alongside DONE.
                    if (r_rnw) begin
                        w_rdata_nxt = M_RDATA;
                    end
                end else begin
                    w_timer_nxt = r_timer - CNT_W'(1);
                end
            end

            FIN: begin
                w_state_nxt = IDLE;
                w_gnt_nxt   = '0;
                w_busy_nxt  = 1'b0;
            end

            default: begin
                w_state_nxt = IDLE;
                w_gnt_nxt   = '0;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state <= IDLE;
            r_timer <= '0;
            r_last  <= c_last_rst;
            r_gnt   <= '0;
            r_done  <= '0;
            r_rdata <= '0;
            r_busy  <= 1'b0;
            r_stb   <= 1'b0;
            r_rnw   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
            r_last  <= w_last_nxt;
            r_gnt   <= w_gnt_nxt;
            r_done  <= w_done_nxt;
            r_rdata <= w_rdata_nxt;
            r_busy  <= w_busy_nxt;
            r_stb   <= w_stb_nxt;
            r_rnw   <= w_rnw_nxt;
            r_addr  <= w_addr_nxt;
            r_wdata <= w_wdata_nxt;
        end
    end

    assign GNT         = r_gnt;
    assign DONE        = r_done;
    assign RDATA       = r_rdata;
    assign BUSY        = r_busy;
    assign M_START_STB = r_stb;
    assign M_RNW       = r_rnw;
    assign M_ADDR      = r_addr;
    assign M_WDATA     = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_i2c_txn_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i2c_txn_arbiter
//  Description : Self-checking bench for i2c_txn_arbiter (NUM_REQ=4,
//                XFER_CYCLES=16). A transaction-timeline reference model is
//                compared against every output each cycle; directed
//                scenarios add hand-computed literal expectations, followed
//                by a randomized phase.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_txn_arbiter;

    localparam int NR = 4;
    localparam int XF = 16;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic [NR-1:0] REQ = '0;
    logic [NR-1:0] REQ_RNW = '0;
    logic [7*NR-1:0]  REQ_ADDR = '0;
    logic [16*NR-1:0] REQ_WDATA = '0;
    logic [15:0]   M_RDATA = '0;
    logic [NR-1:0] GNT;
    logic [NR-1:0] DONE;
    logic [15:0]   RDATA;
    logic          BUSY;
    logic          M_START_STB;
    logic          M_RNW;
    logic [6:0]    M_ADDR;
    logic [15:0]   M_WDATA;

    i2c_txn_arbiter #(
        .NUM_REQ     (NR),
        .XFER_CYCLES (XF)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .REQ         (REQ),
        .REQ_RNW     (REQ_RNW),
        .REQ_ADDR    (REQ_ADDR),
        .REQ_WDATA   (REQ_WDATA),
        .GNT         (GNT),
        .DONE        (DONE),
        .RDATA       (RDATA),
        .BUSY        (BUSY),
        .M_START_STB (M_START_STB),
        .M_RNW       (M_RNW),
        .M_ADDR      (M_ADDR),
        .M_WDATA     (M_WDATA),
        .M_RDATA     (M_RDATA)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc_now  = 0;

    always @(posedge CLK) cyc_now <= cyc_now + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: a transaction is a timeline measured in cycles since
    // the grant edge. Cycle 1 carries the strobe, cycles 1..XF+1 hold the
    // grant, cycle XF+1 carries DONE, then the bus is idle for one cycle
    // before requests are looked at again.
    // ------------------------------------------------------------------
    int          m_phase = 0;
    int          m_owner = 0;
    int          m_last  = NR - 1;
    int          m_c;
    bit          m_found;
    logic        m_rnw   = 1'b0;
    logic [6:0]  m_addr  = '0;
    logic [15:0] m_wdata = '0;
    logic [15:0] m_rdata = '0;
    logic [NR-1:0] e_gnt, e_done;

    initial begin
        forever begin
            @(posedge CLK);
            if (!RST) begin
                m_phase = 0;
                m_last  = NR - 1;
                m_rnw   = 1'b0;
                m_addr  = '0;
                m_wdata = '0;
                m_rdata = '0;
            end else if (m_phase == 0) begin
                m_found = 1'b0;
                for (int k = 1; k <= NR; k++) begin
                    m_c = (m_last + k) % NR;
                    if (!m_found && REQ[m_c]) begin
                        m_found = 1'b1;
                        m_owner = m_c;
                    end
                end
                if (m_found) begin
                    m_last  = m_owner;
                    m_rnw   = REQ_RNW[m_owner];
                    m_addr  = REQ_ADDR[m_owner*7 +: 7];
                    m_wdata = REQ_WDATA[m_owner*16 +: 16];
                    m_phase = 1;
                end
            end else if (m_phase < XF + 1) begin
                m_phase++;
                if (m_phase == XF + 1 && m_rnw) m_rdata = M_RDATA;
            end else begin
                m_phase = 0;
            end
            #1;
            e_gnt  = (m_phase > 0) ? NR'(1 << m_owner) : '0;
            e_done = (m_phase == XF + 1) ? NR'(1 << m_owner) : '0;
            check("model_gnt",   GNT,         e_gnt);
            check("model_done",  DONE,        e_done);
            check("model_busy",  BUSY,        m_phase > 0);
            check("model_stb",   M_START_STB, m_phase == 1);
            check("model_rnw",   M_RNW,       m_rnw);
            check("model_addr",  M_ADDR,      m_addr);
            check("model_wdata", M_WDATA,     m_wdata);
            check("model_rdata", RDATA,       m_rdata);
        end
    end

    // ------------------------------------------------------------------
    // Directed helpers (bounded waits, sampled on the falling edge)
    // ------------------------------------------------------------------
    task automatic set_op(input int i, input logic rnw, input logic [6:0] a, input logic [15:0] d);
        REQ_RNW[i]           = rnw;
        REQ_ADDR[i*7 +: 7]   = a;
        REQ_WDATA[i*16 +: 16] = d;
    endtask

    task automatic wait_stb();
        int n = 0;
        while (n < 100) begin
            @(negedge CLK);
            n++;
            if (M_START_STB === 1'b1) return;
        end
        check("timeout_stb", 0, 1);
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        do begin
            @(negedge CLK);
            cyc++;
        end while (DONE === '0 && cyc < 100);
        if (DONE === '0) check("timeout_done", 0, 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (BUSY !== 1'b0 && n < 100) begin
            @(negedge CLK);
            n++;
        end
        if (BUSY !== 1'b0) check("timeout_idle", 0, 1);
    endtask

    logic [NR-1:0] exp_seq [5];
    int cyc, done_at, stb_at;

    initial begin
        exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        // 1. Reset with everybody requesting
        RST = 1'b0;
        REQ = 4'b1111;
        repeat (3) @(negedge CLK);
        check("rst_gnt",   GNT, 0);
        check("rst_busy",  BUSY, 0);
        check("rst_stb",   M_START_STB, 0);
        check("rst_done",  DONE, 0);
        check("rst_rdata", RDATA, 0);
        check("rst_addr",  M_ADDR, 0);
        RST = 1'b1;
        @(negedge CLK);
        check("rst_first_gnt", GNT, 4'b0001);
        check("rst_first_stb", M_START_STB, 1);
        REQ = '0;
        wait_done(cyc);
        wait_idle();

        // 2. Single write from requester 2
        set_op(2, 1'b0, 7'h50, 16'hA5C3);
        REQ = 4'b0100;
        wait_stb();
        check("wr_gnt",   GNT, 4'b0100);
        check("wr_addr",  M_ADDR, 7'h50);
        check("wr_wdata", M_WDATA, 16'hA5C3);
        check("wr_rnw",   M_RNW, 0);
        @(negedge CLK);
        check("wr_stb_pulse", M_START_STB, 0);
        wait_done(cyc);
        check("wr_latency", cyc + 1, XF);
        check("wr_done",  DONE, 4'b0100);
        check("wr_rdata_hold", RDATA, 16'h0000);
        REQ = '0;
        @(negedge CLK);
        check("wr_after_gnt",  GNT, 0);
        check("wr_after_done", DONE, 0);

        // 3. Single read from requester 1
        set_op(1, 1'b1, 7'h2A, 16'hFFFF);
        M_RDATA = 16'h1234;
        REQ = 4'b0010;
        wait_stb();
        check("rd_gnt", GNT, 4'b0010);
        wait_done(cyc);
        check("rd_done",  DONE, 4'b0010);
        check("rd_rdata", RDATA, 16'h1234);
        REQ = '0;
        wait_idle();

        // 4. Round-robin with all requesters held high
        RST = 1'b0;
        repeat (2) @(negedge CLK);
        REQ = 4'b1111;
        RST = 1'b1;
        done_at = 0;
        for (int i = 0; i < 5; i++) begin
            wait_stb();
            stb_at = cyc_now;
            check("rr_gnt", GNT, exp_seq[i]);
            if (i > 0) check("rr_gap", stb_at - done_at, 2);
            wait_done(cyc);
            done_at = cyc_now;
            check("rr_done", DONE, exp_seq[i]);
        end
        REQ = '0;
        wait_idle();

        // 5. Operand stability and dropped REQ after grant
        set_op(0, 1'b0, 7'h11, 16'hBEEF);
        REQ = 4'b0001;
        wait_stb();
        check("stab_gnt",  GNT, 4'b0001);
        check("stab_addr0", M_ADDR, 7'h11);
        repeat (5) @(negedge CLK);
        REQ_ADDR[6:0] = 7'h7F;
        REQ = '0;
        @(negedge CLK);
        check("stab_addr1", M_ADDR, 7'h11);
        wait_done(cyc);
        check("stab_done",  DONE, 4'b0001);
        check("stab_addr2", M_ADDR, 7'h11);
        check("stab_wdata", M_WDATA, 16'hBEEF);
        wait_idle();

        // 6. Reset in the middle of a transaction
        REQ = 4'b0100;
        wait_stb();
        repeat (7) @(negedge CLK);
        RST = 1'b0;
        REQ = 4'b1011;
        @(negedge CLK);
        check("abort_gnt",  GNT, 0);
        check("abort_busy", BUSY, 0);
        check("abort_done", DONE, 0);
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        check("abort_regrant", GNT, 4'b0001);
        REQ = '0;
        wait_done(cyc);
        check("abort_regrant_done", DONE, 4'b0001);
        wait_idle();

        // Randomized phase: the per-cycle model checks everything
        for (int n = 0; n < 3000; n++) begin
            @(negedge CLK);
            if ($urandom_range(0, 3) == 0) REQ = NR'($urandom);
            REQ_RNW   = NR'($urandom);
            REQ_ADDR  = 28'($urandom);
            REQ_WDATA = {$urandom, $urandom};
            M_RDATA   = 16'($urandom);
            RST       = ($urandom_range(0, 299) != 0);
        end
        @(negedge CLK);
        RST = 1'b1;
        REQ = '0;
        repeat (2 * XF + 8) @(negedge CLK);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/i2c_txn_arbiter.md
Name: i2c_txn_arbiter

Overview:
- Shares one I2C master between NUM_REQ independent requesters.
- Arbitrates round-robin and latches the winner's operands onto the master's START_STB/RNW/I2C_ADDR/WR_DATA inputs.
- Times each transaction with a fixed cycle budget, because the master has no done flag.
- Returns the master's RD_DATA and a one-cycle DONE pulse to the requester that owned the bus.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- XFER_CYCLES, 256, CLK cycles from the M_START_STB pulse to transaction completion (>=2; covers 30+ SCL periods at SCL=CLK/8).
- CNT_W, $clog2(XFER_CYCLES+1), width of the transaction timer.

Ports:
- CLK  input  1  system clock.
- RST  input  1  reset, synchronous, active-low.
- REQ  input  NUM_REQ  per-requester request level.
- REQ_RNW  input  NUM_REQ  per-requester direction (1 = read).
- REQ_ADDR  input  7*NUM_REQ  packed 7-bit slave addresses; requester i uses bits [7i+6:7i].
- REQ_WDATA  input  16*NUM_REQ  packed 16-bit write data; requester i uses bits [16i+15:16i].
- GNT  output  NUM_REQ  one-hot grant, held for the whole transaction.
- DONE  output  NUM_REQ  one-cycle completion pulse to the owner.
- RDATA  output  16  read data, valid in the DONE cycle.
- BUSY  output  1  high while any transaction is in flight.
- M_START_STB  output  1  start strobe to the master.
- M_RNW  output  1  direction to the master.
- M_ADDR  output  7  slave address to the master.
- M_WDATA  output  16  write data to the master.
- M_RDATA  input  16  master's RD_DATA.

Behaviour:
- Reset (RST=0 at posedge CLK): state=IDLE; GNT, DONE, BUSY and M_START_STB = 0; M_RNW=0; M_ADDR=0; M_WDATA=0; RDATA=0; timer=0; last_grant=NUM_REQ-1, so requester 0 has top priority.
- Reset mid-transaction aborts immediately. No DONE is issued, and all outputs take their reset values on the next edge.
- IDLE:
  - Sample REQ. If no bit is set, remain in IDLE.
  - Otherwise pick the winner w as the first set bit scanning from last_grant+1, wrapping modulo NUM_REQ.
  - Next edge: GNT[w]=1, BUSY=1, M_START_STB=1. Latch M_RNW/M_ADDR/M_WDATA from w's slice. last_grant<=w. timer<=XFER_CYCLES-1. Go to RUN.
- RUN:
  - M_START_STB is low from the first RUN cycle; it is a 1-cycle pulse.
  - The timer decrements each cycle. At timer==0, go to FIN.
  - M_* operands stay stable throughout RUN, whatever the requesters do.
- FIN:
  - For exactly one cycle, DONE[w]=1 and GNT[w] stays 1.
  - If M_RNW=1, RDATA<=M_RDATA, captured on entry to FIN. Otherwise RDATA holds its previous value.
  - Next edge: GNT=0, BUSY=0, DONE=0. Go to IDLE.
- Latency: REQ high in IDLE at edge t gives M_START_STB at t+1, DONE at t+1+XFER_CYCLES, and the earliest next grant at t+3+XFER_CYCLES.
- Handshake: a requester holds REQ and its operands until DONE. It may deassert REQ in the DONE cycle; otherwise it is re-queued.
- A REQ dropped before grant is simply not considered. A REQ dropped after grant does not cancel the transaction, and DONE still pulses.
- A requester asserting REQ while BUSY waits. Fairness: with all REQ high, the grant order is 0,1,2,...,NUM_REQ-1,0.
- A single persistent requester is re-granted each round with the 1-cycle IDLE gap.
- GNT and DONE are never multi-hot.

Decomposition:
- Shared package i2c_pkg:
  - State encoding constants: IDLE=2'd0, RUN=2'd1, FIN=2'd2.
  - I2C field widths: ADDR_W=7, DATA_W=16.
  - Default XFER_CYCLES.
- One combinational sub-module, i2c_rr_pick.
  - Inputs: NUM_REQ request vector, last_grant index.
  - Outputs: one-hot winner, winner index, any_req.
- The parent holds the FSM, timer and operand registers.

Test Plan (bench uses NUM_REQ=4, XFER_CYCLES=16):
1. Reset: hold RST=0 for 3 cycles with REQ=4'b1111 -> all outputs 0 and no grant; after RST=1, GNT=4'b0001 one cycle later.
2. Single write: REQ[2]=1, REQ_RNW[2]=0, ADDR=7'h50, WDATA=16'hA5C3 -> GNT=4'b0100, one-cycle M_START_STB, M_ADDR=7'h50, M_WDATA=16'hA5C3, DONE[2] exactly 16 cycles after the strobe, RDATA unchanged.
3. Single read: REQ[1]=1, RNW=1, M_RDATA=16'h1234 driven by the bench -> DONE[1] with RDATA=16'h1234.
4. Round-robin: REQ=4'b1111 held -> GNT sequence 0001,0010,0100,1000,0001, with 1 idle cycle between each FIN and the next grant.
5. Operand stability: change REQ_ADDR[0] and drop REQ[0] mid-RUN -> M_ADDR unchanged and DONE[0] still pulses.
6. Reset mid-RUN: RST=0 at timer=8 -> no DONE, GNT=0, BUSY=0; the next grant goes to requester 0 if requesting.
